decimal_palindrome_seq: RTL and testbench

Sequential, parametrised decimal-palindrome checker. It accepts a WIDTH-bit unsigned binary value over a valid/ready handshake and converts it to DIGITS BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per cycle. It then reports whether the decimal representation reads the same in both directions. Compared with the fixed 4-digit combinational checker it adds:
- width and digit count as parameters;
- a leading-zero-stripping mode;
- overflow detection;
- BCD and digit-count outputs;
- back-pressure on the result.

---
 rtl/decimal_palindrome_seq.sv | 126 ++++++++++++
 tb/tb_decimal_palindrome_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decimal_palindrome_seq.sv
// Sequential decimal-palindrome checker: serial double-dabble conversion of a
// WIDTH-bit value to DIGITS BCD digits, then a mirrored digit compare.
`timescale 1ns/1ps
module decimal_palindrome_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             n,
  input  logic                         strip_lz,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         palindrome,
  output logic                         overflow,
  output logic [$clog2(DIGITS+1)-1:0]  num_digits,
  output logic [4*DIGITS-1:0]          bcd
);

  localparam int ND_W  = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMPARE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] work_q;
  logic [WIDTH-1:0]    bin_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic                strip_q;

  logic [4*DIGITS-1:0] adj_c;
  logic [4*DIGITS-1:0] bcd_shift;
  logic [WIDTH-1:0]    bin_shift;
  logic                shift_out;
  logic                pal_c;
  logic [ND_W-1:0]     nd_c;
  int                  hi_c, k_c, j_c;

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = rst_n && (state_q == S_DONE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_valid) state_d = S_CONVERT;
      S_CONVERT: if (cnt_q == CNT_W'(1)) state_d = S_COMPARE;
      S_COMPARE: state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Add-3 correction on every digit >= 5, then shift {bcd, bin} left; the bit
  // leaving the top digit marks a value that needs more than DIGITS digits.
  always_comb begin
    adj_c = work_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[4*d +: 4] >= 4'd5) adj_c[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
    end
    {shift_out, bcd_shift, bin_shift} = {adj_c, bin_q, 1'b0};
  end

  always_comb begin
    hi_c = 0;
    j_c  = 0;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[4*d +: 4] != 4'd0) hi_c = d + 1;
    end
    if (hi_c == 0) hi_c = 1;
    nd_c  = ND_W'(hi_c);
    k_c   = strip_q ? hi_c : DIGITS;
    pal_c = !ovf_q;
    for (int i = 0; i < DIGITS / 2; i++) begin
      if (i < k_c / 2) begin
        j_c = k_c - 1 - i;
        if (work_q[4*i +: 4] != work_q[4*j_c +: 4]) pal_c = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the conversion registers are reset too, so a reset mid-request leaves no stale state behind.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      strip_q    <= 1'b0;
      palindrome <= 1'b0;
      overflow   <= 1'b0;
      num_digits <= '0;
      bcd        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          bin_q   <= n;
          strip_q <= strip_lz;
          work_q  <= '0;
          ovf_q   <= 1'b0;
          cnt_q   <= CNT_W'(WIDTH);
        end
        S_CONVERT: begin
          work_q <= bcd_shift;
          bin_q  <= bin_shift;
          ovf_q  <= ovf_q | shift_out;
          cnt_q  <= cnt_q - 1'b1;
        end
        S_COMPARE: begin
          palindrome <= pal_c;
          overflow   <= ovf_q;
          num_digits <= nd_c;
          bcd        <= work_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_palindrome_seq.sv
// Self-checking bench: a 5-digit and a 4-digit instance share stimulus; results
// are compared against a table of known cases and an arithmetic reference model.
`timescale 1ns/1ps
module tb_decimal_palindrome_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          strip_lz = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  n = '0;

  logic          in_ready5, out_valid5, pal5, ovf5;
  logic [2:0]    nd5;
  logic [19:0]   bcd5;
  logic          in_ready4, out_valid4, pal4, ovf4;
  logic [2:0]    nd4;
  logic [15:0]   bcd4;

  int total = 0;
  int passed = 0;
  int both_high = 0;

  decimal_palindrome_seq #(.WIDTH(W), .DIGITS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
    .n(n), .strip_lz(strip_lz), .out_valid(out_valid5), .out_ready(out_ready),
    .palindrome(pal5), .overflow(ovf5), .num_digits(nd5), .bcd(bcd5)
  );

  decimal_palindrome_seq #(.WIDTH(W), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .n(n), .strip_lz(strip_lz), .out_valid(out_valid4), .out_ready(out_ready),
    .palindrome(pal4), .overflow(ovf4), .num_digits(nd4), .bcd(bcd4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((out_valid5 && in_ready5) || (out_valid4 && in_ready4)) both_high++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: decimal digits by division, compared as a plain digit array.
  function automatic void model(input int unsigned v, input bit s, input int dn,
                                output bit pal, output bit ovf, output int nd,
                                output int unsigned bcd_v);
    int unsigned lim;
    int unsigned t;
    int dg[8];
    int k;
    lim = 1;
    for (int i = 0; i < dn; i++) lim = lim * 10;
    ovf = (v >= lim);
    t = v % lim;
    bcd_v = 0;
    for (int i = 0; i < dn; i++) begin
      dg[i] = int'(t % 10);
      t = t / 10;
      bcd_v = bcd_v | (int'(dg[i]) << (4 * i));
    end
    nd = 1;
    for (int i = 0; i < dn; i++) if (dg[i] != 0) nd = i + 1;
    k = s ? nd : dn;
    pal = !ovf;
    for (int i = 0; i < k / 2; i++) if (dg[i] != dg[k-1-i]) pal = 1'b0;
  endfunction

  typedef struct {
    logic [15:0] n;
    logic        s;
    logic        p5;
    logic        o5;
    logic [2:0]  d5;
    logic [19:0] b5;
    logic        p4;
    logic        o4;
    logic [2:0]  d4;
    logic [15:0] b4;
  } vec_t;

  vec_t vecs[$];

  task automatic start_req(input logic [15:0] v, input logic s);
    int t;
    t = 0;
    while (!in_ready5 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_request", in_ready5, 1'b1);
    n = v;
    strip_lz = s;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int start, output int lat);
    lat = start;
    while (!out_valid5 && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_dropped", out_valid5, 1'b0);
    check("in_ready_returned", in_ready5, 1'b1);
  endtask

  task automatic check_model(input logic [15:0] v, input logic s);
    bit p; bit o; int d; int unsigned b;
    model(v, s, 5, p, o, d, b);
    check("rand_pal5", pal5, p);
    check("rand_ovf5", ovf5, o);
    check("rand_nd5", nd5, d);
    check("rand_bcd5", bcd5, b);
    model(v, s, 4, p, o, d, b);
    check("rand_pal4", pal4, p);
    check("rand_ovf4", ovf4, o);
    check("rand_nd4", nd4, d);
    check("rand_bcd4", bcd4, b);
  endtask

  initial begin
    int lat;
    int stable;
    int spurious;
    logic [31:0] snap;
    logic [15:0] rv;
    logic rs;

    //          n      s  p5 o5 d5 b5        p4 o4 d4 b4
    vecs.push_back('{16'd12321, 1'b0, 1'b1, 1'b0, 3'd5, 20'h12321, 1'b0, 1'b1, 3'd4, 16'h2321});
    vecs.push_back('{16'd1221,  1'b1, 1'b1, 1'b0, 3'd4, 20'h01221, 1'b1, 1'b0, 3'd4, 16'h1221});
    vecs.push_back('{16'd1221,  1'b0, 1'b0, 1'b0, 3'd4, 20'h01221, 1'b1, 1'b0, 3'd4, 16'h1221});
    vecs.push_back('{16'd0,     1'b0, 1'b1, 1'b0, 3'd1, 20'h00000, 1'b1, 1'b0, 3'd1, 16'h0000});
    vecs.push_back('{16'd0,     1'b1, 1'b1, 1'b0, 3'd1, 20'h00000, 1'b1, 1'b0, 3'd1, 16'h0000});
    vecs.push_back('{16'd65535, 1'b0, 1'b0, 1'b0, 3'd5, 20'h65535, 1'b0, 1'b1, 3'd4, 16'h5535});
    vecs.push_back('{16'd9999,  1'b1, 1'b1, 1'b0, 3'd4, 20'h09999, 1'b1, 1'b0, 3'd4, 16'h9999});
    vecs.push_back('{16'd12021, 1'b0, 1'b1, 1'b0, 3'd5, 20'h12021, 1'b0, 1'b1, 3'd4, 16'h2021});
    vecs.push_back('{16'd10000, 1'b1, 1'b0, 1'b0, 3'd5, 20'h10000, 1'b0, 1'b1, 3'd1, 16'h0000});
    vecs.push_back('{16'd4554,  1'b1, 1'b1, 1'b0, 3'd4, 20'h04554, 1'b1, 1'b0, 3'd4, 16'h4554});
    vecs.push_back('{16'd7,     1'b0, 1'b0, 1'b0, 3'd1, 20'h00007, 1'b0, 1'b0, 3'd1, 16'h0007});
    vecs.push_back('{16'd7,     1'b1, 1'b1, 1'b0, 3'd1, 20'h00007, 1'b1, 1'b0, 3'd1, 16'h0007});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready5, 1'b0);
    check("rst_out_valid", out_valid5, 1'b0);
    check("rst_palindrome", pal5, 1'b0);
    check("rst_overflow", ovf5, 1'b0);
    check("rst_num_digits", nd5, 3'd0);
    check("rst_bcd", bcd5, 20'h0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_reset", in_ready5, 1'b1);

    // Directed table
    foreach (vecs[i]) begin
      start_req(vecs[i].n, vecs[i].s);
      wait_result(0, lat);
      check("latency", lat, 17);
      check("out_valid4", out_valid4, 1'b1);
      check("in_ready_low_in_done", in_ready5, 1'b0);
      check("tbl_pal5", pal5, vecs[i].p5);
      check("tbl_ovf5", ovf5, vecs[i].o5);
      check("tbl_nd5", nd5, vecs[i].d5);
      check("tbl_bcd5", bcd5, vecs[i].b5);
      check("tbl_pal4", pal4, vecs[i].p4);
      check("tbl_ovf4", ovf4, vecs[i].o4);
      check("tbl_nd4", nd4, vecs[i].d4);
      check("tbl_bcd4", bcd4, vecs[i].b4);
      release_result();
    end

    // Back-pressure: outputs held for 10 cycles with out_ready low
    start_req(16'd12321, 1'b0);
    wait_result(0, lat);
    check("bp_latency", lat, 17);
    snap = {8'h0, pal5, ovf5, nd5, bcd5};
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid5 || in_ready5 || ({8'h0, pal5, ovf5, nd5, bcd5} !== snap)) stable = 0;
    end
    check("bp_stable", stable, 1);
    check("bp_bcd", bcd5, 20'h12321);
    release_result();

    // New request and strip_lz change during CONVERT are ignored
    start_req(16'd1221, 1'b0);
    n = 16'd121;
    strip_lz = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_result(4, lat);
    check("ign_latency", lat, 17);
    check("ign_pal", pal5, 1'b0);
    check("ign_bcd", bcd5, 20'h01221);
    check("ign_nd", nd5, 3'd4);
    release_result();

    // Reset pulse mid-CONVERT
    start_req(16'd12321, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready", in_ready5, 1'b0);
    check("mid_rst_outputs", {pal5, ovf5, nd5, bcd5}, 25'h0);
    check("mid_rst_outputs4", {pal4, ovf4, nd4, bcd4}, 21'h0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready_back", in_ready5, 1'b1);
    spurious = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid5 || out_valid4) spurious++;
    end
    check("mid_rst_no_out_valid", spurious, 0);
    start_req(16'd4554, 1'b1);
    wait_result(0, lat);
    check("post_rst_latency", lat, 17);
    check("post_rst_pal", pal5, 1'b1);
    check("post_rst_nd", nd5, 3'd4);
    release_result();

    // Randomized against the reference model, biased toward palindromes
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0)
        rv = 16'(10001 * $urandom_range(1, 5) + 1010 * $urandom_range(0, 9) + 100 * $urandom_range(0, 9));
      else if ($urandom_range(0, 1) == 0)
        rv = 16'($urandom_range(0, 9999));
      else
        rv = 16'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      start_req(rv, rs);
      wait_result(0, lat);
      check("rand_latency", lat, 17);
      check_model(rv, rs);
      release_result();
    end

    check("never_valid_and_ready", both_high, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
